operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
Pipeline stage between instruction decode and execute in the RV32I core. Accepts decoded source-register requests with a valid/ready handshake and issues reads to the integer register file, which has synchronous reads. One cycle later it presents both operands to execute.
Bypasses register-file writes that the synchronous read misses: a write in the same cycle as the read, or writes made while the result is stalled. Execute always sees architecturally current rs1/rs2 values.

Parameters:
XLEN, 32, operand width; equals the core's `RV_XLEN.
SIDE_W, 64, width of the opaque sideband payload (pc, opcode, rd, ...) carried alongside the operands.

Ports:
clk_i  in  1  core clock
resetb_i  in  1  reset
clk_en_i  in  1  global clock enable; when low, all state holds
ids_valid_i  in  1  decode offers an instruction
ids_ready_o  out  1  stage accepts this cycle
ids_rs1_rd_i  in  1  instruction uses rs1
ids_rs1_addr_i  in  5  rs1 index
ids_rs2_rd_i  in  1  instruction uses rs2
ids_rs2_addr_i  in  5  rs2 index
ids_side_i  in  SIDE_W  sideband payload
rreg_a_rd_o  out  1  register-file read port a enable (rs1)
rreg_a_addr_o  out  5  read port a index
rreg_a_data_i  in  XLEN  read port a data, valid the cycle after the read
rreg_b_rd_o  out  1  read port b enable (rs2)
rreg_b_addr_o  out  5  read port b index
rreg_b_data_i  in  XLEN  read port b data
wreg_a_wr_i  in  1  snoop of register-file write port a
wreg_a_addr_i  in  5  write port a index
wreg_a_data_i  in  XLEN  write port a data
wreg_b_wr_i  in  1  snoop of write port b; wins over port a for the same index
wreg_b_addr_i  in  5  write port b index
wreg_b_data_i  in  XLEN  write port b data
exs_valid_o  out  1  operands valid to execute
exs_ready_i  in  1  execute consumes this cycle
exs_rs1_data_o  out  XLEN  rs1 operand
exs_rs2_data_o  out  XLEN  rs2 operand
exs_side_o  out  SIDE_W  registered sideband

Behaviour:
- Clock and reset: one clock, clk_i. Reset resetb_i is asynchronous, active-low.
- All registers update only on posedge clk_i with clk_en_i=1. The register file shares clk_en_i.
- Reset values: exs_valid_o=0; exs_side_o=0; use flags, override flags and override data cleared. exs_rs1_data_o=0 and exs_rs2_data_o=0 out of reset.
- Handshake:
  - ids_ready_o = !exs_valid_o | exs_ready_i (combinational). This is a single-entry stage with full throughput.
  - accept = ids_valid_i & ids_ready_o.
  - rreg_a_rd_o = accept & ids_rs1_rd_i. rreg_a_addr_o = ids_rs1_addr_i, combinational pass-through.
  - rreg_b_rd_o and rreg_b_addr_o follow the same rule for rs2.
  - Read enables stay low during a stall, so the register file holds its output data.
- Slot update on an accept edge:
  - exs_valid_o <= 1; side, addresses and use flags captured.
  - Per operand: if used, addr != 0, and a snooped write hits the addr this cycle, set override <= 1 and override data <= write data (port b wins if both hit). Otherwise override <= 0.
- Slot update on a consume without accept: exs_valid_o <= 0.
- Slot update while held (exs_valid_o=1 and exs_ready_i=0): every snooped write hitting a used, nonzero operand addr updates that operand's override, with the same port-b priority.
- Output mux, per operand:
  - use flag 0 -> 0.
  - addr 0 -> 0. Writes to x0 are never bypassed.
  - override 1 -> override data.
  - otherwise -> rreg_*_data_i.
- Latency: operands appear exactly 1 cycle after accept. Back-to-back accepts run at 1 per cycle.
- clk_en_i=0: no state change, and outputs stay as they are. Decode and execute must not treat a low clk_en_i cycle as a transfer.
- Reset mid-stall: the slot is dropped (exs_valid_o=0). Nothing is replayed.
- Writes to registers not referenced by the held slot are ignored.

Test Plan:
- Basic read: x5=0x1234 preloaded; accept rs1=5, rs2=0 -> next cycle exs_valid_o=1, rs1=0x1234, rs2=0, rreg_a_rd_o pulsed for 1 cycle.
- Same-cycle bypass: accept rs1=7 while wreg_a writes x7=0xDEAD -> rs1=0xDEAD, not the stale value. Repeat with both ports writing x7 (a=1, b=2) -> rs1=2.
- Stall update: slot holds rs2=3 with exs_ready_i=0 for 3 cycles while wreg_b writes x3=0xA then 0xB -> rs2 reads 0xA then 0xB; on release execute sees 0xB, and rreg_b_rd_o stayed 0 during the stall.
- x0 and unused operands: accept rs1=0 with wreg_a writing x0=0xFFFF -> rs1=0. Accept with ids_rs2_rd_i=0 -> rs2=0 and rreg_b_rd_o=0.
- Throughput and enable: 4 back-to-back instructions with exs_ready_i=1 -> 4 consecutive valid cycles in order. Insert clk_en_i=0 for 2 cycles -> all outputs frozen, no drops or duplicates.
- Reset: assert resetb_i low mid-stall, asynchronously -> exs_valid_o=0 and operands=0 immediately. ids_ready_o=1 after release.

Source files
------------

// File: rtl/operand_fetch_if.sv
// Decode/execute/register-file bus for the operand fetch stage.
// master = surrounding core, slave = the stage itself.
interface operand_fetch_if #(
    parameter int XLEN   = 32,
    parameter int SIDE_W = 64
);
    logic              ids_valid_i;
    logic              ids_ready_o;
    logic              ids_rs1_rd_i;
    logic [4:0]        ids_rs1_addr_i;
    logic              ids_rs2_rd_i;
    logic [4:0]        ids_rs2_addr_i;
    logic [SIDE_W-1:0] ids_side_i;
    logic              rreg_a_rd_o;
    logic [4:0]        rreg_a_addr_o;
    logic [XLEN-1:0]   rreg_a_data_i;
    logic              rreg_b_rd_o;
    logic [4:0]        rreg_b_addr_o;
    logic [XLEN-1:0]   rreg_b_data_i;
    logic              wreg_a_wr_i;
    logic [4:0]        wreg_a_addr_i;
    logic [XLEN-1:0]   wreg_a_data_i;
    logic              wreg_b_wr_i;
    logic [4:0]        wreg_b_addr_i;
    logic [XLEN-1:0]   wreg_b_data_i;
    logic              exs_valid_o;
    logic              exs_ready_i;
    logic [XLEN-1:0]   exs_rs1_data_o;
    logic [XLEN-1:0]   exs_rs2_data_o;
    logic [SIDE_W-1:0] exs_side_o;

    modport master (
        output ids_valid_i, ids_rs1_rd_i, ids_rs1_addr_i,
        output ids_rs2_rd_i, ids_rs2_addr_i, ids_side_i,
        output rreg_a_data_i, rreg_b_data_i,
        output wreg_a_wr_i, wreg_a_addr_i, wreg_a_data_i,
        output wreg_b_wr_i, wreg_b_addr_i, wreg_b_data_i,
        output exs_ready_i,
        input  ids_ready_o, rreg_a_rd_o, rreg_a_addr_o,
        input  rreg_b_rd_o, rreg_b_addr_o,
        input  exs_valid_o, exs_rs1_data_o, exs_rs2_data_o, exs_side_o
    );

    modport slave (
        input  ids_valid_i, ids_rs1_rd_i, ids_rs1_addr_i,
        input  ids_rs2_rd_i, ids_rs2_addr_i, ids_side_i,
        input  rreg_a_data_i, rreg_b_data_i,
        input  wreg_a_wr_i, wreg_a_addr_i, wreg_a_data_i,
        input  wreg_b_wr_i, wreg_b_addr_i, wreg_b_data_i,
        input  exs_ready_i,
        output ids_ready_o, rreg_a_rd_o, rreg_a_addr_o,
        output rreg_b_rd_o, rreg_b_addr_o,
        output exs_valid_o, exs_rs1_data_o, exs_rs2_data_o, exs_side_o
    );
endinterface

// File: rtl/operand_fetch.sv
// Decode->execute operand fetch stage: one slot, synchronous
// register-file read, bypass of writes the read cannot see.
module operand_fetch #(
    parameter int XLEN   = 32,
    parameter int SIDE_W = 64
) (
    input  logic             clk_i,
    input  logic             resetb_i,
    input  logic             clk_en_i,
    operand_fetch_if.slave   bus
);
    logic              r_valid;
    logic [SIDE_W-1:0] r_side;
    logic [4:0]        r_addr1;
    logic [4:0]        r_addr2;
    logic              r_use1;
    logic              r_use2;
    logic              r_ovr1;
    logic              r_ovr2;
    logic [XLEN-1:0]   r_odat1;
    logic [XLEN-1:0]   r_odat2;

    logic              w_ready;
    logic              w_accept;
    logic              w_consume;
    logic              w_hold;
    logic [4:0]        w_sel_addr1;
    logic [4:0]        w_sel_addr2;
    logic              w_sel_use1;
    logic              w_sel_use2;
    logic              w_hit_a1;
    logic              w_hit_b1;
    logic              w_hit_a2;
    logic              w_hit_b2;
    logic              w_hit1;
    logic              w_hit2;
    logic [XLEN-1:0]   w_wdat1;
    logic [XLEN-1:0]   w_wdat2;
    logic [XLEN-1:0]   w_rs1;
    logic [XLEN-1:0]   w_rs2;

    assign w_ready   = !r_valid | bus.exs_ready_i;
    assign w_accept  = bus.ids_valid_i & w_ready;
    assign w_consume = r_valid & bus.exs_ready_i;
    assign w_hold    = r_valid & !bus.exs_ready_i;

    // Snoop against the incoming request on accept, else the held slot.
    assign w_sel_addr1 = w_accept ? bus.ids_rs1_addr_i : r_addr1;
    assign w_sel_addr2 = w_accept ? bus.ids_rs2_addr_i : r_addr2;
    assign w_sel_use1  = w_accept ? bus.ids_rs1_rd_i   : r_use1;
    assign w_sel_use2  = w_accept ? bus.ids_rs2_rd_i   : r_use2;

    assign w_hit_a1 = bus.wreg_a_wr_i & (bus.wreg_a_addr_i == w_sel_addr1);
    assign w_hit_b1 = bus.wreg_b_wr_i & (bus.wreg_b_addr_i == w_sel_addr1);
    assign w_hit_a2 = bus.wreg_a_wr_i & (bus.wreg_a_addr_i == w_sel_addr2);
    assign w_hit_b2 = bus.wreg_b_wr_i & (bus.wreg_b_addr_i == w_sel_addr2);

    assign w_hit1 = w_sel_use1 & (|w_sel_addr1) & (w_hit_a1 | w_hit_b1);
    assign w_hit2 = w_sel_use2 & (|w_sel_addr2) & (w_hit_a2 | w_hit_b2);

    // Port b is the later writer, so it wins on a shared index.
    assign w_wdat1 = w_hit_b1 ? bus.wreg_b_data_i : bus.wreg_a_data_i;
    assign w_wdat2 = w_hit_b2 ? bus.wreg_b_data_i : bus.wreg_a_data_i;

    // Slot occupancy, sideband and operand descriptors.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_valid <= 1'b0;
            r_side  <= '0;
            r_addr1 <= '0;
            r_addr2 <= '0;
            r_use1  <= 1'b0;
            r_use2  <= 1'b0;
        end else if (clk_en_i) begin
            if (w_accept) begin
                r_valid <= 1'b1;
                r_side  <= bus.ids_side_i;
                r_addr1 <= bus.ids_rs1_addr_i;
                r_addr2 <= bus.ids_rs2_addr_i;
                r_use1  <= bus.ids_rs1_rd_i;
                r_use2  <= bus.ids_rs2_rd_i;
            end else if (w_consume) begin
                r_valid <= 1'b0;
            end
        end
    end

    // Override capture: fresh on accept, accumulated while held.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_ovr1  <= 1'b0;
            r_ovr2  <= 1'b0;
            r_odat1 <= '0;
            r_odat2 <= '0;
        end else if (clk_en_i) begin
            if (w_accept) begin
                r_ovr1 <= w_hit1;
                r_ovr2 <= w_hit2;
                if (w_hit1) r_odat1 <= w_wdat1;
                if (w_hit2) r_odat2 <= w_wdat2;
            end else if (w_hold) begin
                if (w_hit1) begin
                    r_ovr1  <= 1'b1;
                    r_odat1 <= w_wdat1;
                end
                if (w_hit2) begin
                    r_ovr2  <= 1'b1;
                    r_odat2 <= w_wdat2;
                end
            end
        end
    end

    // Operand select: unused or x0 reads zero, else bypass or file.
    always_comb begin
        w_rs1 = '0;
        w_rs2 = '0;
        if (r_use1 && r_addr1 != 5'd0)
            w_rs1 = r_ovr1 ? r_odat1 : bus.rreg_a_data_i;
        if (r_use2 && r_addr2 != 5'd0)
            w_rs2 = r_ovr2 ? r_odat2 : bus.rreg_b_data_i;
    end

    assign bus.ids_ready_o    = w_ready;
    assign bus.rreg_a_rd_o    = w_accept & bus.ids_rs1_rd_i;
    assign bus.rreg_a_addr_o  = bus.ids_rs1_addr_i;
    assign bus.rreg_b_rd_o    = w_accept & bus.ids_rs2_rd_i;
    assign bus.rreg_b_addr_o  = bus.ids_rs2_addr_i;
    assign bus.exs_valid_o    = r_valid;
    assign bus.exs_rs1_data_o = w_rs1;
    assign bus.exs_rs2_data_o = w_rs2;
    assign bus.exs_side_o     = r_side;
endmodule

// File: tb/tb_operand_fetch.sv
// Randomized scoreboard bench for operand_fetch; the bench's own
// register file doubles as the architectural reference state.
module tb_operand_fetch;
    localparam int XLEN   = 32;
    localparam int SIDE_W = 64;

    typedef struct {
        logic [SIDE_W-1:0] side;
        logic              u1;
        logic [4:0]        a1;
        logic              u2;
        logic [4:0]        a2;
    } item_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic clk_en = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    item_t q[$];
    logic [XLEN-1:0] rf [32] = '{default: '0};

    always #5 clk = ~clk;

    operand_fetch_if #(.XLEN(XLEN), .SIDE_W(SIDE_W)) bus ();

    operand_fetch #(.XLEN(XLEN), .SIDE_W(SIDE_W)) dut (
        .clk_i    (clk),
        .resetb_i (rstn),
        .clk_en_i (clk_en),
        .bus      (bus)
    );

    // Register file: synchronous read of old contents, port b written last.
    always @(posedge clk) begin
        if (clk_en) begin
            if (bus.rreg_a_rd_o) bus.rreg_a_data_i <= rf[bus.rreg_a_addr_o];
            if (bus.rreg_b_rd_o) bus.rreg_b_data_i <= rf[bus.rreg_b_addr_o];
            if (bus.wreg_a_wr_i && bus.wreg_a_addr_i != 0)
                rf[bus.wreg_a_addr_i] <= bus.wreg_a_data_i;
            if (bus.wreg_b_wr_i && bus.wreg_b_addr_i != 0)
                rf[bus.wreg_b_addr_i] <= bus.wreg_b_data_i;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] opval(input logic u, input logic [4:0] a);
        return (u && a != 0) ? rf[a] : '0;
    endfunction

    // Monitor: compares the presented slot against the model each cycle.
    initial begin
        item_t it;
        logic  exp_rdy;
        logic  acc;
        forever begin
            @(negedge clk or negedge rstn);
            #1;
            if (!rstn) begin
                q.delete();
                chk("rst_valid", 64'(bus.exs_valid_o), 64'(0));
                chk("rst_rs1", 64'(bus.exs_rs1_data_o), 64'(0));
                chk("rst_rs2", 64'(bus.exs_rs2_data_o), 64'(0));
                chk("rst_side", 64'(bus.exs_side_o), 64'(0));
                chk("rst_ready", 64'(bus.ids_ready_o), 64'(1));
            end else begin
                exp_rdy = (q.size() == 0) || bus.exs_ready_i;
                acc = bus.ids_valid_i && exp_rdy;
                chk("valid", 64'(bus.exs_valid_o), 64'(q.size() != 0));
                chk("ready", 64'(bus.ids_ready_o), 64'(exp_rdy));
                chk("rd_a", 64'(bus.rreg_a_rd_o), 64'(acc && bus.ids_rs1_rd_i));
                chk("rd_b", 64'(bus.rreg_b_rd_o), 64'(acc && bus.ids_rs2_rd_i));
                if (acc && bus.ids_rs1_rd_i)
                    chk("addr_a", 64'(bus.rreg_a_addr_o), 64'(bus.ids_rs1_addr_i));
                if (acc && bus.ids_rs2_rd_i)
                    chk("addr_b", 64'(bus.rreg_b_addr_o), 64'(bus.ids_rs2_addr_i));
                if (bus.exs_valid_o && q.size() != 0) begin
                    it = q[0];
                    chk("rs1", 64'(bus.exs_rs1_data_o), 64'(opval(it.u1, it.a1)));
                    chk("rs2", 64'(bus.exs_rs2_data_o), 64'(opval(it.u2, it.a2)));
                    chk("side", bus.exs_side_o, it.side);
                end
                if (clk_en) begin
                    if (q.size() != 0 && bus.exs_ready_i) void'(q.pop_front());
                    if (acc) begin
                        it.side = bus.ids_side_i;
                        it.u1 = bus.ids_rs1_rd_i;
                        it.a1 = bus.ids_rs1_addr_i;
                        it.u2 = bus.ids_rs2_rd_i;
                        it.a2 = bus.ids_rs2_addr_i;
                        q.push_back(it);
                    end
                end
            end
        end
    end

    task automatic drive(
        input logic v,
        input logic u1, input logic [4:0] a1,
        input logic u2, input logic [4:0] a2,
        input logic wa, input logic [4:0] waa, input logic [XLEN-1:0] wad,
        input logic wb, input logic [4:0] wba, input logic [XLEN-1:0] wbd,
        input logic rdy, input logic en);
        bus.ids_valid_i    = v;
        bus.ids_rs1_rd_i   = u1;
        bus.ids_rs1_addr_i = a1;
        bus.ids_rs2_rd_i   = u2;
        bus.ids_rs2_addr_i = a2;
        bus.ids_side_i     = {$urandom, $urandom};
        bus.wreg_a_wr_i    = wa;
        bus.wreg_a_addr_i  = waa;
        bus.wreg_a_data_i  = wad;
        bus.wreg_b_wr_i    = wb;
        bus.wreg_b_addr_i  = wba;
        bus.wreg_b_data_i  = wbd;
        bus.exs_ready_i    = rdy;
        clk_en             = en;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    endtask

    initial begin
        bus.rreg_a_data_i = '0;
        bus.rreg_b_data_i = '0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle();
        rstn = 1'b1;
        idle();
        // preload x5, x7, x3
        drive(0, 0, 0, 0, 0, 1, 5, 32'h1234, 1, 7, 32'h5555, 1, 1);
        drive(0, 0, 0, 0, 0, 1, 3, 32'h0303, 0, 0, 0, 1, 1);
        // basic read
        drive(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle();
        // same-cycle bypass, single then dual port
        drive(1, 1, 7, 0, 0, 1, 7, 32'hDEAD, 0, 0, 0, 1, 1);
        idle();
        drive(1, 1, 7, 0, 0, 1, 7, 32'h1, 1, 7, 32'h2, 1, 1);
        idle();
        // stall with rs2=3 updated twice
        drive(1, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 32'hA, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 32'hB, 0, 1);
        drive(1, 1, 4, 1, 4, 0, 0, 0, 0, 0, 0, 0, 1);
        idle();
        // x0 and unused operand
        drive(1, 1, 0, 0, 0, 1, 0, 32'hFFFF, 0, 0, 0, 1, 1);
        drive(1, 1, 5, 0, 9, 0, 0, 0, 0, 0, 0, 1, 1);
        idle();
        // back-to-back, then clock enable low for two cycles
        for (int i = 0; i < 4; i++)
            drive(1, 1, 5'(i + 1), 1, 5'(i + 2), 0, 0, 0, 0, 0, 0, 1, 1);
        drive(1, 1, 6, 1, 7, 1, 6, 32'h66, 0, 0, 0, 1, 0);
        drive(1, 1, 6, 1, 7, 0, 0, 0, 1, 7, 32'h77, 1, 0);
        drive(1, 1, 2, 1, 3, 0, 0, 0, 0, 0, 0, 1, 1);
        idle();
        // reset asserted asynchronously mid-stall
        drive(1, 1, 5, 1, 7, 0, 0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        #2 rstn = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        idle();
        // randomized traffic
        for (int i = 0; i < 3000; i++)
            drive(1'($urandom_range(0, 3) != 0),
                  1'($urandom), 5'($urandom_range(0, 7)),
                  1'($urandom), 5'($urandom_range(0, 7)),
                  1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 7) != 0));
        for (int i = 0; i < 4; i++) idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
